// File: rtl/gpio_cmd_bridge.sv
// Bridges a MicroBlaze GPIO word pair into a req/ack command port for four
// configuration registers and a free-running 32-bit cycle counter.
module gpio_cmd_bridge #(
  parameter int NB_GPIOS = 32,
  parameter int NB_CFG   = 16
) (
  input  logic                clockdsp,
  input  logic                in_reset,
  input  logic [NB_GPIOS-1:0] i_gpo,
  output logic [NB_GPIOS-1:0] o_gpi,
  output logic [NB_CFG-1:0]   o_cfg0,
  output logic [NB_CFG-1:0]   o_cfg1,
  output logic [NB_CFG-1:0]   o_cfg2,
  output logic [NB_CFG-1:0]   o_cfg3
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_REL} state_e;

  typedef enum logic [7:0] {
    OP_WR_REG    = 8'h01,
    OP_RD_REG    = 8'h02,
    OP_RD_CNT_LO = 8'h03,
    OP_RD_CNT_HI = 8'h04,
    OP_CLR_CNT   = 8'h05
  } opcode_e;

  typedef struct packed {
    logic [7:0]  opcode;
    logic        req;
    logic [2:0]  rsvd;
    logic [3:0]  addr;
    logic [15:0] data;
  } gpo_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [3:0]  addr;
    logic [15:0] data;
  } cmd_t;

  state_e            state_q;
  gpo_t              r_gpo_q;
  cmd_t              cmd_q;
  logic [NB_CFG-1:0] cfg_q [4];
  logic [NB_CFG-1:0] cfg_d [4];
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       snap_q, snap_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              ack_q;
  logic              err_q, err_d;
  logic              addr_ok;
  logic              gpo_unused;

  assign addr_ok    = (cmd_q.addr[3:2] == 2'b00);
  assign gpo_unused = ^r_gpo_q.rsvd;

  // Command execution; the results only land on the EXEC->WAIT_REL edge.
  always_comb begin
    // NOTE: every *_d gets a default before any branch, so no path leaves a
    // signal unassigned and no latch can be inferred.
    cfg_d   = cfg_q;
    snap_d  = snap_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q + 32'd1;
    if (state_q == EXEC) begin
      unique case (cmd_q.opcode)
        OP_WR_REG: begin
          if (addr_ok) cfg_d[cmd_q.addr[1:0]] = NB_CFG'(cmd_q.data);
          else         err_d = 1'b1;
        end
        OP_RD_REG: begin
          if (addr_ok) rdata_d = 16'(cfg_q[cmd_q.addr[1:0]]);
          else         err_d = 1'b1;
        end
        OP_RD_CNT_LO: begin
          snap_d  = cnt_q;
          rdata_d = cnt_q[15:0];
        end
        OP_RD_CNT_HI: rdata_d = snap_q[31:16];
        OP_CLR_CNT:   cnt_d   = 32'd0;
        default:      err_d   = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clockdsp) begin
    // NOTE: state is written only with <= so every register samples the
    // pre-edge values, independent of statement order.
    if (!in_reset) begin
      state_q <= IDLE;
      r_gpo_q <= '0;
      cmd_q   <= '0;
      // NOTE: the cfg array is reset explicitly because its zero contents are
      // visible on o_cfgN straight out of reset.
      cfg_q   <= '{default: '0};
      cnt_q   <= '0;
      snap_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      r_gpo_q <= gpo_t'(i_gpo);
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      rdata_q <= rdata_d;
      unique case (state_q)
        IDLE: begin
          if (r_gpo_q.req) begin
            cmd_q   <= '{opcode: r_gpo_q.opcode, addr: r_gpo_q.addr, data: r_gpo_q.data};
            state_q <= EXEC;
          end
        end
        EXEC: begin
          ack_q   <= 1'b1;
          err_q   <= err_d;
          state_q <= WAIT_REL;
        end
        WAIT_REL: begin
          if (!r_gpo_q.req) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_gpi  = NB_GPIOS'({ack_q, err_q, 14'd0, rdata_q});
  assign o_cfg0 = cfg_q[0];
  assign o_cfg1 = cfg_q[1];
  assign o_cfg2 = cfg_q[2];
  assign o_cfg3 = cfg_q[3];

endmodule

// File: tb/tb_gpio_cmd_bridge.sv
// Bench for gpio_cmd_bridge: a command-level reference model compared every
// cycle, plus directed sequences with hand-computed expectations.
module tb_gpio_cmd_bridge;

  logic        clockdsp = 1'b0;
  logic        in_reset;
  logic [31:0] i_gpo;
  logic [31:0] o_gpi;
  logic [15:0] o_cfg0, o_cfg1, o_cfg2, o_cfg3;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clockdsp = ~clockdsp;

  gpio_cmd_bridge #(.NB_GPIOS(32), .NB_CFG(16)) dut (
    .clockdsp (clockdsp),
    .in_reset (in_reset),
    .i_gpo    (i_gpo),
    .o_gpi    (o_gpi),
    .o_cfg0   (o_cfg0),
    .o_cfg1   (o_cfg1),
    .o_cfg2   (o_cfg2),
    .o_cfg3   (o_cfg3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: tracks how far the current handshake has progressed
  // (0 = no command, 1 = accepted, 2 = done and waiting for req to drop).
  logic [31:0] m_seen, m_cmd, m_cnt, m_snap;
  logic [15:0] m_cfg [4];
  logic [15:0] m_rdata;
  logic        m_ack, m_err, m_clr;
  int          m_step, m_op, m_a;

  always @(posedge clockdsp) begin
    if (in_reset !== 1'b1) begin
      m_seen = '0; m_cmd = '0; m_cnt = '0; m_snap = '0; m_rdata = '0;
      m_ack = 1'b0; m_err = 1'b0; m_step = 0;
      for (int i = 0; i < 4; i++) m_cfg[i] = '0;
    end else begin
      m_clr = 1'b0;
      if (m_step == 2) begin
        if (!m_seen[23]) begin m_ack = 1'b0; m_step = 0; end
      end else if (m_step == 1) begin
        m_op  = int'(m_cmd[31:24]);
        m_a   = int'(m_cmd[19:16]);
        m_err = 1'b0;
        case (m_op)
          1: if (m_a < 4) m_cfg[m_a] = m_cmd[15:0]; else m_err = 1'b1;
          2: if (m_a < 4) m_rdata = m_cfg[m_a];     else m_err = 1'b1;
          3: begin m_snap = m_cnt; m_rdata = m_cnt[15:0]; end
          4: m_rdata = m_snap[31:16];
          5: m_clr = 1'b1;
          default: m_err = 1'b1;
        endcase
        m_ack  = 1'b1;
        m_step = 2;
      end else if (m_seen[23]) begin
        m_cmd  = m_seen;
        m_step = 1;
      end
      m_cnt  = m_clr ? 32'd0 : m_cnt + 32'd1;
      m_seen = i_gpo;
    end
  end

  always @(negedge clockdsp) begin
    if (cmp_en) begin
      check("gpi",  o_gpi, {m_ack, m_err, 14'd0, m_rdata});
      check("cfg0", {16'd0, o_cfg0}, {16'd0, m_cfg[0]});
      check("cfg1", {16'd0, o_cfg1}, {16'd0, m_cfg[1]});
      check("cfg2", {16'd0, o_cfg2}, {16'd0, m_cfg[2]});
      check("cfg3", {16'd0, o_cfg3}, {16'd0, m_cfg[3]});
      check("cnt",  dut.cnt_q, m_cnt);
    end
  end

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [3:0] a,
                                     input logic [15:0] d, input logic req);
    return {op, req, 3'b000, a, d};
  endfunction

  task automatic tick();
    @(posedge clockdsp);
    #2;
  endtask

  // Full handshake with exact ack timing; optionally scrambles data while held.
  task automatic send(input logic [7:0] op, input logic [3:0] a, input logic [15:0] d,
                      input int hold, input bit scramble, output logic [31:0] g);
    i_gpo = mk(op, a, d, 1'b1);
    tick();
    tick();
    check("ack_before_k2", 32'(o_gpi[31]), 32'd0);
    tick();
    check("ack_at_k2", 32'(o_gpi[31]), 32'd1);
    g = o_gpi;
    for (int i = 0; i < hold; i++) begin
      if (scramble) i_gpo[15:0] = 16'($urandom);
      tick();
    end
    check("ack_held", 32'(o_gpi[31]), 32'd1);
    i_gpo = mk(op, a, d, 1'b0);
    tick();
    check("ack_until_m1", 32'(o_gpi[31]), 32'd1);
    tick();
    check("ack_cleared", 32'(o_gpi[31]), 32'd0);
  endtask

  logic [31:0] g;
  int          hold;
  logic [7:0]  op;

  initial begin
    in_reset = 1'b0;
    i_gpo    = '0;
    tick();
    cmp_en = 1'b1;
    tick();
    tick();
    check("rst_gpi", o_gpi, 32'h0);
    check("rst_cfg", {o_cfg0, o_cfg1} | {o_cfg2, o_cfg3}, 32'h0);
    check("rst_cnt", dut.cnt_q, 32'h0);
    in_reset = 1'b1;
    tick();

    // Write then read back cfg2.
    send(8'h01, 4'd2, 16'hBEEF, 0, 1'b0, g);
    check("wr2_gpi", g, 32'h8000_0000);
    check("wr2_cfg2", {16'd0, o_cfg2}, 32'h0000_BEEF);
    send(8'h02, 4'd2, 16'h0000, 0, 1'b0, g);
    check("rd2_gpi", g, 32'h8000_BEEF);

    // Long hold with data changing: exactly one write of the latched data.
    send(8'h01, 4'd1, 16'h1234, 50, 1'b1, g);
    check("hold_gpi", g, 32'h8000_BEEF);
    check("hold_cfg1", {16'd0, o_cfg1}, 32'h0000_1234);

    // Error cases leave cfg and rdata alone; a good command clears err.
    send(8'h01, 4'd5, 16'hFFFF, 0, 1'b0, g);
    check("err_addr", g, 32'hC000_BEEF);
    send(8'h7F, 4'd0, 16'h1111, 0, 1'b0, g);
    check("err_op", g, 32'hC000_BEEF);
    send(8'h02, 4'd9, 16'h0000, 0, 1'b0, g);
    check("err_rdaddr", g, 32'hC000_BEEF);
    check("err_cfg", {o_cfg0, o_cfg3}, 32'h0);
    send(8'h02, 4'd1, 16'h0000, 0, 1'b0, g);
    check("err_clear", g, 32'h8000_1234);

    // Clear, wait 0x10000 cycles, snapshot, then read the high half twice.
    send(8'h05, 4'd0, 16'h0000, 0, 1'b0, g);
    check("clr_gpi", g, 32'h8000_1234);
    repeat (32'h10000) tick();
    send(8'h03, 4'd0, 16'h0000, 0, 1'b0, g);
    check("cnt_lo", g, 32'h8000_0004);
    repeat (37) tick();
    send(8'h04, 4'd0, 16'h0000, 0, 1'b0, g);
    check("cnt_hi", g, 32'h8000_0001);
    repeat (113) tick();
    send(8'h04, 4'd0, 16'h0000, 0, 1'b0, g);
    check("cnt_hi_again", g, 32'h8000_0001);

    // Counter wrap.
    dut.cnt_q = 32'hFFFF_FFFE;
    m_cnt     = 32'hFFFF_FFFE;
    tick();
    check("wrap_max", dut.cnt_q, 32'hFFFF_FFFF);
    tick();
    check("wrap_zero", dut.cnt_q, 32'h0);

    // Clear landing on the wrap edge.
    i_gpo = mk(8'h05, 4'd0, 16'h0, 1'b1);
    tick();
    dut.cnt_q = 32'hFFFF_FFFE;
    m_cnt     = 32'hFFFF_FFFE;
    tick();
    check("clrwrap_max", dut.cnt_q, 32'hFFFF_FFFF);
    tick();
    check("clrwrap_zero", dut.cnt_q, 32'h0);
    check("clrwrap_ack", 32'(o_gpi[31]), 32'd1);
    tick();
    check("clrwrap_resume", dut.cnt_q, 32'h1);
    i_gpo = '0;
    tick();
    tick();

    // Reset during WAIT_REL with req still high: one re-execution.
    i_gpo = mk(8'h01, 4'd3, 16'hA5A5, 1'b1);
    tick(); tick(); tick();
    check("pre_rst_cfg3", {16'd0, o_cfg3}, 32'h0000_A5A5);
    in_reset = 1'b0;
    tick();
    check("midrst_gpi", o_gpi, 32'h0);
    check("midrst_cfg", {o_cfg0, o_cfg1} | {o_cfg2, o_cfg3}, 32'h0);
    in_reset = 1'b1;
    tick(); tick();
    check("rerun_pending", {o_gpi[31], 15'd0, o_cfg3}, 32'h0);
    tick();
    check("rerun_ack", 32'(o_gpi[31]), 32'd1);
    check("rerun_cfg3", {16'd0, o_cfg3}, 32'h0000_A5A5);
    i_gpo[15:0] = 16'h1111;
    repeat (10) tick();
    check("rerun_once", {16'd0, o_cfg3}, 32'h0000_A5A5);
    i_gpo[23] = 1'b0;
    tick(); tick();
    check("rerun_release", 32'(o_gpi[31]), 32'd0);

    // Randomized traffic, checked every cycle against the model.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        in_reset = 1'b0;
        tick();
        in_reset = 1'b1;
      end
      case ($urandom_range(0, 7))
        0, 1:    op = 8'h01;
        2:       op = 8'h02;
        3:       op = 8'h03;
        4:       op = 8'h04;
        5:       op = 8'h05;
        6:       op = 8'h02;
        default: op = 8'($urandom);
      endcase
      i_gpo = {op, 1'b1, 3'($urandom), 4'($urandom_range(0, 5)), 16'($urandom)};
      hold  = $urandom_range(1, 6);
      for (int i = 0; i < hold; i++) begin
        if ($urandom_range(0, 3) == 0) i_gpo[22:0] = 23'($urandom);
        tick();
      end
      i_gpo = {8'($urandom), 1'b0, 23'($urandom)};
      repeat ($urandom_range(1, 4)) tick();
    end

    i_gpo = '0;
    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_cmd_bridge.md
GPIO_CMD_BRIDGE -- requirements
Module: gpio_cmd_bridge

Interface
REQ-001 SHALL have parameter NB_GPIOS, default 32: width of the GPIO words; only 32 is supported.
REQ-002 SHALL have parameter NB_CFG, default 16: width of each configuration register.
REQ-003 SHALL have port clockdsp, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port in_reset, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port i_gpo, input, 32: MicroBlaze GPIO output word, synchronous to clockdsp.
REQ-006 SHALL have port o_gpi, output, 32: status/readback word to the MicroBlaze GPIO input.
REQ-007 SHALL have ports o_cfg0, o_cfg1, o_cfg2, o_cfg3, output, 16 each: configuration register contents.

Function
REQ-008 SHALL decode i_gpo as follows: [31:24] opcode, [23] req, [22:20] unused, [19:16] addr, [15:0] data.
REQ-009 SHALL map o_gpi as follows: [31] ack, [30] err, [29:16] zero, [15:0] rdata.
REQ-010 SHALL register i_gpo into r_gpo every cycle; all decoding SHALL use r_gpo only.
REQ-011 SHALL implement the FSM states IDLE, EXEC and WAIT_REL with these transitions:
- IDLE->EXEC when r_gpo.req=1.
- EXEC->WAIT_REL unconditionally.
- WAIT_REL->IDLE when r_gpo.req=0.
REQ-012 SHALL latch opcode, addr and data on the IDLE->EXEC edge; later i_gpo changes SHALL NOT affect the command in flight.
REQ-013 SHALL execute the command and set ack=1 on the EXEC->WAIT_REL edge: req high at i_gpo before edge k gives ack=1 after edge k+2.
REQ-014 SHALL clear ack on the WAIT_REL->IDLE edge; dropping req at i_gpo before edge m gives ack=0 after edge m+1.
REQ-015 SHALL start a new command only from IDLE; if req is held high, exactly one execution occurs.
REQ-016 SHALL implement the following opcodes:
- 0x01 WR_REG: cfg[addr] <= data for addr 0..3; for addr>3, no write and err=1.
- 0x02 RD_REG: rdata <= cfg[addr] for addr 0..3; for addr>3, rdata unchanged and err=1.
- 0x03 RD_CNT_LO: snap <= cnt; rdata <= cnt[15:0].
- 0x04 RD_CNT_HI: rdata <= snap[31:16] without re-capturing.
- 0x05 CLR_CNT: cnt <= 0.
- Any other opcode: no effect, err=1.
REQ-017 SHALL update err at each command completion (1 on error, else 0) and hold it until the next completion.
REQ-018 SHALL change rdata only on successful read opcodes.
REQ-019 SHALL keep cnt as a 32-bit free-running counter incrementing every cycle, wrapping 0xFFFFFFFF->0.
REQ-020 SHALL, on CLR_CNT, make cnt 0 at the execute edge, with incrementing resuming the next cycle; clear SHALL win over increment.
REQ-021 SHALL drive o_cfgN directly from the registers, updating on the execute edge of WR_REG.

Reset
REQ-022 SHALL, while in_reset=0 at a clock edge, load the following values:
- state=IDLE, r_gpo=0, cfg0..3=0, cnt=0, snap=0, rdata=0, ack=0, err=0.
- Hence o_gpi=0x00000000 and all o_cfgN=0.
REQ-023 SHALL, on reset mid-command (EXEC or WAIT_REL), abort the command, leaving any register update from a completed EXEC edge intact.
REQ-024 SHALL, if req is high when reset releases, execute that command once (level-sensitive); no edge history is kept.

Verification
REQ-025 SHALL cover WR_REG 0x01, addr 2, data 0xBEEF, then RD_REG addr 2 -> o_cfg2=0xBEEF; o_gpi=0x8000BEEF while ack; err=0.
REQ-026 SHALL cover req high at edge k -> ack=1 after edge k+2; req held 50 cycles -> cfg written once, ack stays 1; req low -> ack=0 one edge later.
REQ-027 SHALL cover WR_REG addr 5 or opcode 0x7F -> err=1, ack=1, cfg0..3 and rdata unchanged; next valid command -> err=0.
REQ-028 SHALL cover CLR_CNT, wait 0x10000 cycles, RD_CNT_LO, then RD_CNT_HI -> HI returns 0x0001 from the same snapshot, independent of the delay between the reads.
REQ-029 SHALL cover forcing cnt to 0xFFFFFFFE and checking 0xFFFFFFFF, then 0x00000000; CLR_CNT on the wrap cycle -> cnt=0.
REQ-030 SHALL cover in_reset=0 during WAIT_REL -> o_gpi=0 and o_cfgN=0 next edge; req still high on release -> command re-executes once.
